variance_sample_driver: RTL and testbench
=========================================

// Module: variance_sample_driver
// PURPOSE
//  Transmit side of the variance handshake. Buffers up to DEPTH signed 13-bit samples from
//  upstream, then plays them into the variance unit:
//  - drives signal_in with a one-cycle ready strobe per sample, then a one-cycle done strobe;
//  - waits for standby, then captures n_var as result.
//  Sits between the ADC/sample front end and the variance block.
// PARAMETERS
//  DEPTH     256  sample buffer entries; legal 1..256 (variance unit holds max 256)
//  WAIT_MIN  2    min cycles after done falls before standby is trusted and n_var sampled
//  WAIT_MAX  64   cycles in WAIT before a forced capture with timeout flag
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   synchronous active-low reset
//  wr_en         in   1   write wr_data into buffer (honoured only in IDLE)
//  wr_data       in   13  signed sample to buffer
//  start         in   1   begin streaming buffered samples (one-cycle pulse, IDLE only)
//  signal_in     out  13  signed sample to variance unit
//  ready         out  1   sample strobe to variance unit
//  done          out  1   end-of-block strobe to variance unit
//  standby       in   1   variance unit idle/result-stable indication
//  n_var         in   13  signed variance result from variance unit
//  result        out  13  captured n_var
//  result_valid  out  1   one-cycle pulse when result updates
//  busy          out  1   high from accepted start to result_valid
//  fill          out  9   buffered sample count, 0..DEPTH
//  ovf           out  1   sticky: write attempted while full, or while busy
//  timeout       out  1   sticky: WAIT reached WAIT_MAX without standby
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, fill=0, state IDLE, buffer contents don't-care.
//  Reset mid-stream: aborts immediately; ready/done drop the next edge; buffer emptied.
//  State machine:
//  - IDLE: wr_en && fill<DEPTH -> buf[fill]<=wr_data, fill++.
//    - wr_en && fill==DEPTH -> dropped, ovf<=1.
//    - start && fill>0 -> SETUP, busy<=1, rd_ptr<=0.
//    - start && fill==0 -> ignored (no done with zero count: divide-by-zero in variance unit).
//    - start and wr_en same cycle: write lands first and is included in the block.
//  - SETUP: signal_in<=buf[rd_ptr], ready=0 -> STROBE.
//  - STROBE: ready=1 exactly one cycle, signal_in held -> GAP.
//  - GAP: ready=0 one cycle, signal_in held; rd_ptr++.
//    - -> SETUP if rd_ptr+1<fill, else -> DONE.
//  - DONE: done=1 exactly one cycle, signal_in held, ready=0 -> WAIT.
//  - WAIT: count cycles from 1.
//    - capture when count>=WAIT_MIN && standby==1.
//    - or at count==WAIT_MAX: capture anyway, timeout<=1.
//    - -> CAPTURE.
//  - CAPTURE: result<=n_var, result_valid=1 one cycle, busy<=0, fill<=0 -> IDLE.
//  Rules:
//  - signal_in changes only in SETUP (never while ready=1).
//  - ready and done are never high together.
//  - wr_en while busy: dropped, ovf<=1.
//  - start while busy: ignored.
//  - Per sample: 3 cycles (SETUP/STROBE/GAP). Latency start->result_valid = 3*fill + 1 + WAIT + 1.
//  - result holds until next capture.
//  - ovf and timeout clear only on reset.
//  - Buffer is read-only during streaming and is reset to empty after each capture.
// CONFIGURATION
//  NOISE_THRESH_EN defined:
//  - adds ports thresh (in 13, signed) and noise_high (out 1, reset 0);
//  - noise_high<=(n_var>thresh) in CAPTURE, signed compare, held until next capture.
//  NOISE_THRESH_EN undefined: ports absent, no comparator; all other behaviour identical.
// TESTING
//  1. Reset then idle: all outputs 0, fill=0; start with fill=0 -> busy stays 0, no ready/done.
//  2. Write 10,-10,10,-10; start; model n_var=100 with standby high ->
//     - exactly 4 ready pulses carrying 10,-10,10,-10;
//     - one done pulse;
//     - result=100, result_valid one cycle, fill=0.
//  3. Write DEPTH+1 samples -> fill=DEPTH, ovf=1.
//     Stream -> exactly DEPTH ready pulses, signal_in stable through each pulse.
//  4. Hold standby=0 after done -> capture at WAIT_MAX, timeout=1.
//     Next block with standby=1 -> capture at WAIT_MIN, timeout still 1.
//  5. rst_n=0 during 3rd sample of a 5-sample block -> next edge: ready=done=busy=0, fill=0.
//     No done is ever issued for that block.
//  6. NOISE_THRESH_EN, thresh=50:
//     - n_var=100 -> noise_high=1;
//     - next block, n_var=50 -> noise_high=0.

Source files
------------

// File: rtl/variance_sample_driver.sv
`default_nettype none
// ============================================================================
// Module   : variance_sample_driver
// Purpose  : Transmit side of the variance handshake. Buffers up to DEPTH
//            signed 13-bit samples, plays them into the variance unit one at
//            a time (one-cycle ready strobe per sample, one-cycle done strobe
//            at the end), then waits for standby and captures n_var.
// Ports    : clk, rst_n (sync, active low)
//            wr_en/wr_data  - sample buffer write (IDLE only)
//            start          - begin streaming (IDLE only, needs >=1 sample)
//            signal_in/ready/done - stream to variance unit
//            standby/n_var  - variance unit status and result
//            result/result_valid - captured result and update pulse
//            busy, fill, ovf (sticky), timeout (sticky)
// Options  : NOISE_THRESH_EN adds thresh (in) and noise_high (out); noise_high
//            is the signed compare n_var > thresh at each capture.
// Revision : 1.0 - initial release
// ============================================================================
module variance_sample_driver #(
  parameter int DEPTH    = 256,
  parameter int WAIT_MIN = 2,
  parameter int WAIT_MAX = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic signed [12:0] wr_data,
  input  logic               start,
  output logic signed [12:0] signal_in,
  output logic               ready,
  output logic               done,
  input  logic               standby,
  input  logic signed [12:0] n_var,
  output logic signed [12:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic [8:0]         fill,
  output logic               ovf,
  output logic               timeout
`ifdef NOISE_THRESH_EN
  ,
  input  logic signed [12:0] thresh,
  output logic               noise_high
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [8:0]    FILL_MAX  = 9'(DEPTH);
  localparam logic [CW-1:0] WAIT_LO   = CW'(WAIT_MIN);
  localparam logic [CW-1:0] WAIT_HI   = CW'(WAIT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4,
    ST_WAIT    = 3'd5,
    ST_CAPTURE = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic signed [12:0]  r_mem [DEPTH];
  logic [8:0]          r_rd_ptr;
  logic [CW-1:0]       r_wait_cnt;

  logic w_wr_ok;
  logic w_wr_drop;
  logic w_start_ok;
  logic w_last;
  logic w_standby_ok;
  logic w_wait_expired;
  logic w_capture;

  // Any write outside IDLE happens while busy, so every non-accepted write
  // is either "full" or "busy" and both set ovf.
  assign w_wr_ok        = (r_state == ST_IDLE) && wr_en && (fill < FILL_MAX);
  assign w_wr_drop      = wr_en && !w_wr_ok;
  // A write in the same cycle as start counts toward the block, so a start
  // with an empty buffer is still accepted when that write lands.
  assign w_start_ok     = (r_state == ST_IDLE) && start && ((fill != 9'd0) || w_wr_ok);
  assign w_last         = (r_rd_ptr + 9'd1) >= fill;
  assign w_standby_ok   = (r_wait_cnt >= WAIT_LO) && standby;
  assign w_wait_expired = (r_wait_cnt == WAIT_HI);
  assign w_capture      = (r_state == ST_WAIT) && (w_standby_ok || w_wait_expired);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok) w_state_nx = ST_SETUP;
      ST_SETUP:   w_state_nx = ST_STROBE;
      ST_STROBE:  w_state_nx = ST_GAP;
      ST_GAP:     w_state_nx = w_last ? ST_DONE : ST_SETUP;
      ST_DONE:    w_state_nx = ST_WAIT;
      ST_WAIT:    if (w_capture) w_state_nx = ST_CAPTURE;
      ST_CAPTURE: w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  // Sample storage; contents are don't-care after reset, fill defines validity.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[fill[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd_ptr     <= 9'd0;
      r_wait_cnt   <= '0;
      signal_in    <= '0;
      ready        <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      fill         <= 9'd0;
      ovf          <= 1'b0;
      timeout      <= 1'b0;
`ifdef NOISE_THRESH_EN
      noise_high   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nx;
      // Strobes are registered from the next state so they are glitch-free
      // and coincide exactly with the STROBE / DONE / CAPTURE cycles.
      ready        <= (w_state_nx == ST_STROBE);
      done         <= (w_state_nx == ST_DONE);
      result_valid <= (w_state_nx == ST_CAPTURE);

      if (w_wr_ok)   fill <= fill + 9'd1;
      if (w_wr_drop) ovf  <= 1'b1;

      if (w_start_ok) begin
        busy     <= 1'b1;
        r_rd_ptr <= 9'd0;
      end

      case (r_state)
        ST_SETUP:   signal_in  <= r_mem[r_rd_ptr[AW-1:0]];
        ST_GAP:     r_rd_ptr   <= r_rd_ptr + 9'd1;
        ST_DONE:    r_wait_cnt <= CW'(1);
        ST_WAIT:    r_wait_cnt <= r_wait_cnt + CW'(1);
        ST_CAPTURE: begin
          busy <= 1'b0;
          fill <= 9'd0;
        end
        default: ;
      endcase

      // n_var is sampled in the same cycle standby qualified it, so the
      // captured value is visible while result_valid is high.
      if (w_capture) begin
        result <= n_var;
        if (!w_standby_ok) timeout <= 1'b1;
`ifdef NOISE_THRESH_EN
        noise_high <= (n_var > thresh);
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_variance_sample_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_variance_sample_driver
// Purpose  : Directed self-checking bench for variance_sample_driver. The
//            variance unit is modelled by driving standby/n_var directly.
// Options  : NOISE_THRESH_EN enables the threshold-compare steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_variance_sample_driver;

  localparam int DEPTH    = 256;
  localparam int WAIT_MIN = 2;
  localparam int WAIT_MAX = 64;

  logic               clk;
  logic               rst_n;
  logic               wr_en;
  logic signed [12:0] wr_data;
  logic               start;
  logic signed [12:0] signal_in;
  logic               ready;
  logic               done;
  logic               standby;
  logic signed [12:0] n_var;
  logic signed [12:0] result;
  logic               result_valid;
  logic               busy;
  logic [8:0]         fill;
  logic               ovf;
  logic               timeout;
`ifdef NOISE_THRESH_EN
  logic signed [12:0] thresh;
  logic               noise_high;
`endif

  variance_sample_driver #(
    .DEPTH    (DEPTH),
    .WAIT_MIN (WAIT_MIN),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .start        (start),
    .signal_in    (signal_in),
    .ready        (ready),
    .done         (done),
    .standby      (standby),
    .n_var        (n_var),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .fill         (fill),
    .ovf          (ovf),
    .timeout      (timeout)
`ifdef NOISE_THRESH_EN
    ,
    .thresh       (thresh),
    .noise_high   (noise_high)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Stream observer: records what the variance unit would see.
  logic signed [12:0] samples [$];
  logic signed [12:0] wq [$];
  int                 n_ready   = 0;
  int                 n_done    = 0;
  int                 n_overlap = 0;
  int                 n_unstable = 0;
  logic               prev_ready = 1'b0;
  logic signed [12:0] prev_sig   = '0;

  always @(negedge clk) begin
    if (ready) begin
      samples.push_back(signal_in);
      n_ready++;
    end
    if (done) n_done++;
    if (ready && done) n_overlap++;
    if (prev_ready && busy && (signal_in !== prev_sig)) n_unstable++;
    prev_ready = ready;
    prev_sig   = signal_in;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called and returns on a falling edge.
  task automatic wr(input logic signed [12:0] d, input bit kept);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    if (kept) wq.push_back(d);
  endtask

  task automatic run_block(input string tag, input int nsamp, input int exp_lat,
                           input logic signed [12:0] exp_res);
    int base_r;
    int base_d;
    int base_q;
    int cyc;
    logic signed [12:0] obs;
    base_r = n_ready;
    base_d = n_done;
    base_q = samples.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy_hi"}, busy, 1);
    while (!result_valid && cyc < exp_lat + WAIT_MAX + 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_rvalid"}, result_valid, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_nready"}, n_ready - base_r, nsamp);
    check({tag, "_ndone"}, n_done - base_d, 1);
    for (int i = 0; i < nsamp; i++) begin
      obs = (base_q + i < samples.size()) ? samples[base_q + i] : 'x;
      check({tag, "_sample"}, obs, wq[i]);
    end
    wq.delete();
    @(negedge clk);
    check({tag, "_rvalid_lo"}, result_valid, 0);
    check({tag, "_busy_lo"}, busy, 0);
    check({tag, "_fill_clr"}, fill, 0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r;
    int base_d;
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    start   = 1'b0;
    standby = 1'b0;
    n_var   = '0;
`ifdef NOISE_THRESH_EN
    thresh  = 13'sd50;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state, start with an empty buffer is ignored
    check("rst_signal_in", signal_in, 0);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fill", fill, 0);
    check("rst_ovf", ovf, 0);
    check("rst_timeout", timeout, 0);
`ifdef NOISE_THRESH_EN
    check("rst_noise_high", noise_high, 0);
`endif
    base_r = n_ready;
    base_d = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("empty_start_busy", busy, 0);
    check("empty_start_ready", n_ready - base_r, 0);
    check("empty_start_done", n_done - base_d, 0);

    // 2: four-sample block, standby already high
    wr(13'sd10, 1'b1);
    wr(-13'sd10, 1'b1);
    wr(13'sd10, 1'b1);
    wr(-13'sd10, 1'b1);
    check("t2_fill", fill, 4);
    standby = 1'b1;
    n_var   = 13'sd100;
    run_block("t2", 4, 3*4 + 1 + WAIT_MIN + 1, 13'sd100);
    check("t2_ovf", ovf, 0);
    check("t2_timeout", timeout, 0);

    // 3: overfill by one, then stream the full buffer
    for (int i = 0; i <= DEPTH; i++) begin
      wr(13'(i * 7 - 900), (i < DEPTH));
    end
    check("t3_fill_full", fill, DEPTH);
    check("t3_ovf", ovf, 1);
    n_var = -13'sd5;
    run_block("t3", DEPTH, 3*DEPTH + 1 + WAIT_MIN + 1, -13'sd5);
    check("t3_stable", n_unstable, 0);
    check("t3_overlap", n_overlap, 0);

    // 4: standby never arrives -> forced capture, then a normal block
    standby = 1'b0;
    n_var   = 13'sd33;
    wr(13'sd5, 1'b1);
    wr(13'sd7, 1'b1);
    check("t4_timeout_pre", timeout, 0);
    run_block("t4a", 2, 3*2 + 1 + WAIT_MAX + 1, 13'sd33);
    check("t4a_timeout", timeout, 1);
    standby = 1'b1;
    n_var   = 13'sd44;
    wr(-13'sd1, 1'b1);
    run_block("t4b", 1, 3*1 + 1 + WAIT_MIN + 1, 13'sd44);
    check("t4b_timeout_sticky", timeout, 1);

    // 5: reset during the third sample's strobe
    standby = 1'b0;
    for (int i = 0; i < 5; i++) wr(13'(i + 1), 1'b0);
    base_d = n_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("t5_third_strobe", ready, 1);
    check("t5_third_value", signal_in, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_ready", ready, 0);
    check("t5_done", done, 0);
    check("t5_busy", busy, 0);
    check("t5_fill", fill, 0);
    check("t5_ovf_clr", ovf, 0);
    check("t5_timeout_clr", timeout, 0);
    check("t5_result_clr", result, 0);
    repeat (30) @(negedge clk);
    check("t5_no_done", n_done - base_d, 0);
    check("t5_idle_busy", busy, 0);

`ifdef NOISE_THRESH_EN
    // 6: threshold compare
    standby = 1'b1;
    thresh  = 13'sd50;
    n_var   = 13'sd100;
    wr(13'sd1, 1'b1);
    run_block("t6a", 1, 3 + 1 + WAIT_MIN + 1, 13'sd100);
    check("t6a_noise_high", noise_high, 1);
    n_var = 13'sd50;
    wr(13'sd2, 1'b1);
    run_block("t6b", 1, 3 + 1 + WAIT_MIN + 1, 13'sd50);
    check("t6b_noise_high", noise_high, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
